alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Execute-stage front end that drives the shared ALU. It accepts one decoded RV32I instruction per cycle over a valid/ready handshake and encodes opcode/funct3/funct7 into the 4-bit ALU op. It selects the ALU operands, resolves branches and jumps from the ALU zero/result outputs, and registers the outcome into a single-entry EX/MEM output register with its own valid/ready handshake.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  drop the held output and any accepted input this cycle
in_valid  in  1  decoded instruction present
in_ready  out  1  stage can accept this cycle
in_opcode  in  7  instr[6:0]
in_funct3  in  3  instr[14:12]
in_funct7b5  in  1  instr[30]
in_rs1_val  in  32  rs1 operand
in_rs2_val  in  32  rs2 operand
in_imm  in  32  sign-extended immediate, already formatted per type
in_pc  in  32  instruction PC
in_rd  in  5  destination register
out_valid  out  1  EX/MEM entry valid
out_ready  in  1  downstream accepts entry
out_result  out  32  writeback value
out_rd  out  5  destination register
out_reg_write  out  1  writeback enable (forced 0 when rd==0)
out_redirect  out  1  taken branch or jump
out_target  out  32  redirect PC
out_illegal  out  1  unsupported opcode/funct combination
retired  out  CNT_W  count of entries accepted downstream

Behaviour:
- Reset (async, rst_n=0): out_valid=0; out_result, out_rd, out_reg_write, out_redirect, out_target, out_illegal all 0; retired=0.
- Handshake: in_ready = !out_valid || out_ready (combinational). An input transfer occurs when in_valid && in_ready. The stage loads the output register on the next rising edge, so latency is 1 cycle. Output fields stay stable while out_valid && !out_ready.
- out_valid: set on an input transfer, cleared on an output transfer with no new input. A simultaneous output and input transfer keeps it at 1 with the new data.
- retired increments on each out_valid && out_ready and wraps modulo 2^CNT_W.
- flush: highest priority. On the next edge out_valid=0 and any input transfer in that cycle is discarded. retired counts an output transfer that occurs in the same cycle as flush.
- ALU op encoding (shared constants): ADD=0, SUB=1, SLL=2, XOR=3, OR=4, AND=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- OP (0110011): a=rs1, b=rs2. funct3 mapping: 000 gives ADD, or SUB when funct7b5=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7b5=1; 110 OR; 111 AND.
- OP-IMM (0010011): same mapping with b=imm, except funct3=000 is always ADD. Shift ops use b = {27'b0, imm[4:0]}. An OP shift masks rs2 to [4:0] the same way.
- LUI (0110111): a=0, b=imm, ADD.
- AUIPC (0010111): a=pc, b=imm, ADD.
- JAL (1101111): result = pc+4, target = pc+imm, redirect=1.
- JALR (1100111, funct3=000): result = pc+4, target = (rs1+imm) with bit0 cleared, redirect=1.
- BRANCH (1100011): reg_write=0, target = pc+imm.
  - BEQ/BNE use SUB with taken = zero / !zero.
  - BLT/BGE use SLT with taken = result[0] / !result[0].
  - BLTU/BGEU use SLTU with taken = result[0] / !result[0].
  - funct3 010 and 011 are illegal.
- Address adds (pc+4, pc+imm, rs1+imm) use dedicated 32-bit adders, not the ALU, and wrap modulo 2^32.
- Illegal encoding: out_illegal=1, reg_write=0, redirect=0, result=0. The entry still occupies the slot and is handshaken normally.
- out_reg_write = writes_rd && (in_rd != 0).

Decomposition:
- Shared defines header holds the ALU op codes and the RV32I opcode constants.
- One sub-module, alu_op_decode: combinational mapping of opcode/funct3/funct7b5 to ALU op, operand selects, and instruction class.
- The shared ALU is instantiated inside this stage.

Test Plan:
- ADD/SUB: OP, funct3=000, rs1=5, rs2=7, funct7b5=1, rd=3 -> after 1 cycle out_valid=1, out_result=0xFFFFFFFE, out_rd=3, reg_write=1.
- SRAI masking: rs1=0x80000000, imm=0x00000404 (funct7b5=0, SRLI) -> 0x08000000. Same input with funct7b5=1 (SRAI) -> 0xF8000000.
- Branch: BLTU rs1=1, rs2=0xFFFFFFFF, pc=0x100, imm=-8 -> redirect=1, target=0xF8, reg_write=0. BGE rs1=-1, rs2=0 -> redirect=0.
- Backpressure: hold out_ready=0 for 3 cycles after one transfer -> in_ready=0, outputs stable, retired unchanged. Then release with a new in_valid -> simultaneous transfer, retired=1, new data loaded.
- JALR rs1=0x1003, imm=2, pc=0x40 -> target=0x1004, result=0x44. Same instruction with rd=0 -> reg_write=0. funct3=010 BRANCH -> out_illegal=1.
- Flush and reset: flush with in_valid=1 and out_valid=1 -> next cycle out_valid=0. Assert rst_n=0 mid-backpressure -> all outputs and retired return to 0 immediately.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// alu_issue_stage_pkg: ALU op codes, RV32I opcodes and decode types shared by the issue stage
package alu_issue_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_XOR  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_AND  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011,
                           OPC_OPIMM  = 7'b0010011,
                           OPC_LUI    = 7'b0110111,
                           OPC_AUIPC  = 7'b0010111,
                           OPC_JAL    = 7'b1101111,
                           OPC_JALR   = 7'b1100111,
                           OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
    typedef enum logic [1:0] {CLS_ALU, CLS_JAL, CLS_JALR, CLS_BRANCH} cls_e;

    typedef struct packed {
        alu_op_e op;
        a_sel_e  a_sel;
        logic    b_imm;
        logic    shift;
        cls_e    cls;
        logic    writes_rd;
        logic    illegal;
    } dec_t;

    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_stage_alu.sv
// alu_issue_stage_alu: shared integer ALU with zero flag
module alu_issue_stage_alu
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e         i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero
);

    // One result per op code; shift amounts come pre-masked from the caller
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << i_b[4:0];
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_SRL:  o_result = i_a >> i_b[4:0];
            ALU_SRA:  o_result = $signed(i_a) >>> i_b[4:0];
            ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, i_a < i_b};
            default:  o_result = '0;
        endcase
    end

    assign o_zero = o_result == '0;

endmodule

// File: rtl/alu_issue_stage_alu_op_decode.sv
// alu_op_decode: maps opcode/funct3/funct7b5 to ALU op, operand selects and instruction class
module alu_op_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output dec_t       o_dec
);

    // OP-IMM ignores funct7b5 for ADDI but honours it for SRAI; illegal encodings collapse to a no-write ALU entry
    always_comb begin
        o_dec       = '0;
        o_dec.op    = ALU_ADD;
        o_dec.a_sel = A_RS1;
        o_dec.cls   = CLS_ALU;
        case (i_opcode)
            OPC_OP, OPC_OPIMM: begin
                o_dec.op        = arith_op(i_funct3, i_funct7b5 && (i_opcode == OPC_OP || i_funct3 != 3'b000));
                o_dec.b_imm     = i_opcode == OPC_OPIMM;
                o_dec.shift     = i_funct3[1:0] == 2'b01;
                o_dec.writes_rd = 1'b1;
            end
            OPC_LUI: begin
                o_dec.a_sel     = A_ZERO;
                o_dec.b_imm     = 1'b1;
                o_dec.writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                o_dec.a_sel     = A_PC;
                o_dec.b_imm     = 1'b1;
                o_dec.writes_rd = 1'b1;
            end
            OPC_JAL: begin
                o_dec.cls       = CLS_JAL;
                o_dec.writes_rd = 1'b1;
            end
            OPC_JALR: begin
                o_dec.cls       = CLS_JALR;
                o_dec.writes_rd = 1'b1;
                o_dec.illegal   = i_funct3 != 3'b000;
            end
            OPC_BRANCH: begin
                o_dec.cls     = CLS_BRANCH;
                o_dec.op      = i_funct3[2] ? (i_funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                o_dec.illegal = i_funct3[2:1] == 2'b01;
            end
            default: o_dec.illegal = 1'b1;
        endcase
        if (o_dec.illegal) begin
            o_dec.writes_rd = 1'b0;
            o_dec.cls       = CLS_ALU;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I execute front end driving the shared ALU into a single-entry EX/MEM register
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic [XLEN-1:0]  in_rs1_val,
    input  logic [XLEN-1:0]  in_rs2_val,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [4:0]       out_rd,
    output logic             out_reg_write,
    output logic             out_redirect,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [CNT_W-1:0] retired
);

    dec_t            w_dec;
    logic [XLEN-1:0] w_a, w_b_raw, w_b, w_alu_res, w_pc4, w_br_tgt, w_jalr_tgt, w_result;
    logic            w_zero, w_taken, w_jump, w_redirect, w_in_fire, w_out_fire;

    logic             r_valid, r_reg_write, r_redirect, r_illegal;
    logic [XLEN-1:0]  r_result, r_target;
    logic [4:0]       r_rd;
    logic [CNT_W-1:0] r_retired;

    alu_op_decode u_dec (
        .i_opcode   (in_opcode),
        .i_funct3   (in_funct3),
        .i_funct7b5 (in_funct7b5),
        .o_dec      (w_dec)
    );

    alu_issue_stage_alu #(.XLEN(XLEN)) u_alu (
        .i_op     (w_dec.op),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_alu_res),
        .o_zero   (w_zero)
    );

    assign w_a        = w_dec.a_sel == A_PC ? in_pc : (w_dec.a_sel == A_ZERO ? '0 : in_rs1_val);
    assign w_b_raw    = w_dec.b_imm ? in_imm : in_rs2_val;
    assign w_b        = w_dec.shift ? {{(XLEN-5){1'b0}}, w_b_raw[4:0]} : w_b_raw;
    assign w_pc4      = in_pc + XLEN'(4);
    assign w_br_tgt   = in_pc + in_imm;
    assign w_jalr_tgt = (in_rs1_val + in_imm) & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign w_taken    = (in_funct3[2] ? w_alu_res[0] : w_zero) ^ in_funct3[0];
    assign w_jump     = w_dec.cls == CLS_JAL || w_dec.cls == CLS_JALR;
    assign w_redirect = w_jump || (w_dec.cls == CLS_BRANCH && w_taken);
    assign w_result   = w_dec.illegal ? '0 : (w_jump ? w_pc4 : w_alu_res);

    assign in_ready   = !r_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_valid && out_ready;

    // EX/MEM register: flush beats a new load, a new load beats a drain; retired counts every drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_result    <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_redirect  <= 1'b0;
            r_target    <= '0;
            r_illegal   <= 1'b0;
            r_retired   <= '0;
        end else begin
            if (w_out_fire) r_retired <= r_retired + 1'b1;
            if (flush) r_valid <= 1'b0;
            else if (w_in_fire) begin
                r_valid     <= 1'b1;
                r_result    <= w_result;
                r_rd        <= in_rd;
                r_reg_write <= w_dec.writes_rd && in_rd != 5'd0;
                r_redirect  <= w_redirect;
                r_target    <= w_dec.cls == CLS_JALR ? w_jalr_tgt : w_br_tgt;
                r_illegal   <= w_dec.illegal;
            end else if (w_out_fire) r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_result    = r_result;
    assign out_rd        = r_rd;
    assign out_reg_write = r_reg_write;
    assign out_redirect  = r_redirect;
    assign out_target    = r_target;
    assign out_illegal   = r_illegal;
    assign retired       = r_retired;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized checks of alu_issue_stage against a behavioural RV32I model
module tb_alu_issue_stage;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_funct7b5 = 1'b0, out_ready = 1'b0;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0, in_pc = '0;
    logic [4:0]  in_rd = '0;
    logic        in_ready, out_valid, out_reg_write, out_redirect, out_illegal;
    logic [31:0] out_result, out_target, retired;
    logic [4:0]  out_rd;

    typedef struct packed {
        logic        v;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        redir;
        logic [31:0] tgt;
        logic        ill;
    } ent_t;

    ent_t        obs, exp_e, m;
    int          tests = 0, fails = 0;
    logic [31:0] exp_ret = '0;

    assign obs = {out_valid, out_result, out_rd, out_reg_write, out_redirect, out_target, out_illegal};

    alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_redirect(out_redirect), .out_target(out_target), .out_illegal(out_illegal),
        .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic ent_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                                   input logic [31:0] pc, input logic [4:0] rd);
        ent_t        e;
        logic        wr, t;
        logic [31:0] b;
        e = '0; e.v = 1'b1; e.rd = rd; wr = 1'b0; t = 1'b0;
        b = (op == 7'h33) ? rs2 : imm;
        case (op)
            7'h33, 7'h13: begin
                wr = 1'b1;
                case (f3)
                    3'd0: e.res = (f7 && op == 7'h33) ? rs1 - b : rs1 + b;
                    3'd1: e.res = rs1 << b[4:0];
                    3'd2: e.res = {31'b0, $signed(rs1) < $signed(b)};
                    3'd3: e.res = {31'b0, rs1 < b};
                    3'd4: e.res = rs1 ^ b;
                    3'd5: if (f7) e.res = $signed(rs1) >>> b[4:0]; else e.res = rs1 >> b[4:0];
                    3'd6: e.res = rs1 | b;
                    default: e.res = rs1 & b;
                endcase
            end
            7'h37: begin wr = 1'b1; e.res = imm; end
            7'h17: begin wr = 1'b1; e.res = pc + imm; end
            7'h6f: begin wr = 1'b1; e.res = pc + 4; e.tgt = pc + imm; e.redir = 1'b1; end
            7'h67: if (f3 == 3'd0) begin
                wr = 1'b1; e.res = pc + 4; e.tgt = (rs1 + imm) & 32'hFFFF_FFFE; e.redir = 1'b1;
            end else e.ill = 1'b1;
            7'h63: begin
                case (f3)
                    3'd0: t = rs1 == rs2;
                    3'd1: t = rs1 != rs2;
                    3'd4: t = $signed(rs1) < $signed(rs2);
                    3'd5: t = $signed(rs1) >= $signed(rs2);
                    3'd6: t = rs1 < rs2;
                    3'd7: t = rs1 >= rs2;
                    default: e.ill = 1'b1;
                endcase
                if (!e.ill) begin e.redir = t; e.tgt = pc + imm; end
            end
            default: e.ill = 1'b1;
        endcase
        e.rw = wr && rd != 5'd0;
        return e;
    endfunction

    // Branch results and the target of a non-redirecting entry are not architecturally defined
    function automatic ent_t dc_mask(input ent_t e, input logic is_branch);
        ent_t k;
        k = '1;
        if (is_branch && !e.ill) k.res = '0;
        if (!e.redir) k.tgt = '0;
        return k;
    endfunction

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        in_opcode = op; in_funct3 = f3; in_funct7b5 = f7; in_rs1_val = rs1;
        in_rs2_val = rs2; in_imm = imm; in_pc = pc; in_rd = rd; in_valid = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        tests++;
        if (obs !== '0 || retired !== 32'd0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL reset: got obs=%h retired=%0d in_ready=%b want 0/0/1", obs, retired, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_add_sub;
        out_ready = 1'b1;
        drive(7'h33, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3);
        tick;
        in_valid = 1'b0;
        exp_e = {1'b1, 32'hFFFF_FFFE, 5'd3, 1'b1, 1'b0, 32'h0, 1'b0}; m = dc_mask(exp_e, 1'b0);
        tests++;
        if ((obs & m) !== (exp_e & m)) begin fails++; $display("FAIL add_sub: got %h want %h", obs, exp_e); end
        tick; exp_ret++;
        tests++;
        if (out_valid !== 1'b0 || retired !== exp_ret) begin
            fails++; $display("FAIL add_sub_drain: got valid=%b retired=%0d want 0/%0d", out_valid, retired, exp_ret);
        end
    endtask

    task automatic test_shift;
        drive(7'h13, 3'd5, 1'b0, 32'h8000_0000, 32'd0, 32'h0000_0404, 32'd0, 5'd1);
        tick;
        exp_e = {1'b1, 32'h0800_0000, 5'd1, 1'b1, 1'b0, 32'h0, 1'b0}; m = dc_mask(exp_e, 1'b0);
        tests++;
        if ((obs & m) !== (exp_e & m)) begin fails++; $display("FAIL srli: got %h want %h", obs, exp_e); end
        in_funct7b5 = 1'b1;
        tick; exp_ret++;
        exp_e = {1'b1, 32'hF800_0000, 5'd1, 1'b1, 1'b0, 32'h0, 1'b0}; m = dc_mask(exp_e, 1'b0);
        tests++;
        if ((obs & m) !== (exp_e & m) || retired !== exp_ret) begin
            fails++; $display("FAIL srai: got %h ret=%0d want %h ret=%0d", obs, retired, exp_e, exp_ret);
        end
        in_valid = 1'b0;
        tick; exp_ret++;
    endtask

    task automatic test_branch;
        drive(7'h63, 3'd6, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h100, 5'd7);
        tick;
        exp_e = {1'b1, 32'h0, 5'd7, 1'b0, 1'b1, 32'h0000_00F8, 1'b0}; m = dc_mask(exp_e, 1'b1);
        tests++;
        if ((obs & m) !== (exp_e & m)) begin fails++; $display("FAIL bltu: got %h want %h", obs, exp_e); end
        drive(7'h63, 3'd5, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd8, 32'h100, 5'd7);
        tick; exp_ret++;
        exp_e = {1'b1, 32'h0, 5'd7, 1'b0, 1'b0, 32'h0, 1'b0}; m = dc_mask(exp_e, 1'b1);
        tests++;
        if ((obs & m) !== (exp_e & m)) begin fails++; $display("FAIL bge: got %h want %h", obs, exp_e); end
        in_valid = 1'b0;
        tick; exp_ret++;
    endtask

    task automatic test_backpressure;
        ent_t held;
        out_ready = 1'b0;
        drive(7'h33, 3'd0, 1'b0, 32'd10, 32'd20, 32'd0, 32'd0, 5'd4);
        tick;
        drive(7'h33, 3'd0, 1'b1, 32'd100, 32'd1, 32'd0, 32'd0, 5'd5);
        held = {1'b1, 32'd30, 5'd4, 1'b1, 1'b0, 32'h0, 1'b0}; m = dc_mask(held, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (in_ready !== 1'b0 || (obs & m) !== (held & m) || retired !== exp_ret) begin
                fails++; $display("FAIL stall%0d: got rdy=%b obs=%h ret=%0d want 0 %h %0d", i, in_ready, obs, retired, held, exp_ret);
            end
            tick;
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL release_ready: got %b want 1", in_ready); end
        tick; exp_ret++;
        exp_e = {1'b1, 32'd99, 5'd5, 1'b1, 1'b0, 32'h0, 1'b0}; m = dc_mask(exp_e, 1'b0);
        tests++;
        if ((obs & m) !== (exp_e & m) || retired !== exp_ret) begin
            fails++; $display("FAIL simultaneous: got %h ret=%0d want %h ret=%0d", obs, retired, exp_e, exp_ret);
        end
        in_valid = 1'b0;
        tick; exp_ret++;
    endtask

    task automatic test_jalr;
        out_ready = 1'b1;
        drive(7'h67, 3'd0, 1'b0, 32'h1003, 32'd0, 32'd2, 32'h40, 5'd1);
        tick;
        exp_e = {1'b1, 32'h44, 5'd1, 1'b1, 1'b1, 32'h1004, 1'b0}; m = dc_mask(exp_e, 1'b0);
        tests++;
        if ((obs & m) !== (exp_e & m)) begin fails++; $display("FAIL jalr: got %h want %h", obs, exp_e); end
        in_rd = 5'd0;
        tick; exp_ret++;
        exp_e = {1'b1, 32'h44, 5'd0, 1'b0, 1'b1, 32'h1004, 1'b0}; m = dc_mask(exp_e, 1'b0);
        tests++;
        if ((obs & m) !== (exp_e & m)) begin fails++; $display("FAIL jalr_rd0: got %h want %h", obs, exp_e); end
        drive(7'h63, 3'd2, 1'b0, 32'd1, 32'd1, 32'd4, 32'h40, 5'd2);
        tick; exp_ret++;
        exp_e = {1'b1, 32'h0, 5'd2, 1'b0, 1'b0, 32'h0, 1'b1}; m = dc_mask(exp_e, 1'b1);
        tests++;
        if ((obs & m) !== (exp_e & m)) begin fails++; $display("FAIL illegal_branch: got %h want %h", obs, exp_e); end
        in_valid = 1'b0;
        tick; exp_ret++;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(7'h33, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd6);
        tick;
        flush = 1'b1;
        drive(7'h33, 3'd4, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 5'd7);
        tick;
        flush = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || retired !== exp_ret) begin
            fails++; $display("FAIL flush_stalled: got valid=%b ret=%0d want 0/%0d", out_valid, retired, exp_ret);
        end
        tick;
        flush = 1'b1; out_ready = 1'b1;
        tick; exp_ret++;
        flush = 1'b0; in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || retired !== exp_ret) begin
            fails++; $display("FAIL flush_drain: got valid=%b ret=%0d want 0/%0d", out_valid, retired, exp_ret);
        end
    endtask

    task automatic test_random;
        logic [6:0] ops [8];
        logic       mval, mbr, fin, fout;
        ent_t       mexp, nxt;
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03};
        mval = 1'b0; mbr = 1'b0; mexp = '0;
        for (int n = 0; n < 400; n++) begin
            drive(ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom), $urandom, $urandom,
                  $urandom, $urandom, 5'($urandom));
            if (in_opcode == 7'h67 && $urandom_range(0, 1) == 0) in_funct3 = 3'd0;
            if ($urandom_range(0, 3) == 0) in_rs2_val = in_rs1_val;
            if ($urandom_range(0, 3) == 0) in_rd = 5'd0;
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 19) == 0;
            #1;
            tests++;
            if (in_ready !== (!mval || out_ready)) begin
                fails++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, in_ready, !mval || out_ready);
            end
            fin = in_valid && (!mval || out_ready);
            fout = mval && out_ready;
            nxt = model(in_opcode, in_funct3, in_funct7b5, in_rs1_val, in_rs2_val, in_imm, in_pc, in_rd);
            tick;
            if (fout) exp_ret++;
            if (flush) mval = 1'b0;
            else if (fin) begin mval = 1'b1; mexp = nxt; mbr = in_opcode == 7'h63; end
            else if (fout) mval = 1'b0;
            m = dc_mask(mexp, mbr);
            tests++;
            if (out_valid !== mval || retired !== exp_ret || (mval && (obs & m) !== (mexp & m))) begin
                fails++; $display("FAIL rnd[%0d]: got %h ret=%0d want v=%b %h ret=%0d", n, obs, retired, mval, mexp, exp_ret);
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick;
        if (mval) exp_ret++;
        tests++;
        if (out_valid !== 1'b0 || retired !== exp_ret) begin
            fails++; $display("FAIL rnd_drain: got valid=%b ret=%0d want 0/%0d", out_valid, retired, exp_ret);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(7'h33, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd9);
        tick;
        in_valid = 1'b0;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        exp_ret = '0;
        tests++;
        if (obs !== '0 || retired !== exp_ret) begin
            fails++; $display("FAIL reset_mid: got obs=%h ret=%0d want 0/0", obs, retired);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        tests++;
        if (obs !== '0 || retired !== exp_ret || in_ready !== 1'b1) begin
            fails++; $display("FAIL post_reset: got obs=%h ret=%0d rdy=%b want 0/0/1", obs, retired, in_ready);
        end
    endtask

    initial begin
        test_reset;
        test_add_sub;
        test_shift;
        test_branch;
        test_backpressure;
        test_jalr;
        test_flush;
        test_random;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
